// File: rtl/itch_axis_pkg.sv
// Shared types and lane helpers for the ITCH AXIS byte serializer.
// Optional statistics outputs are enabled by defining ITCH_SER_STATS_EN.
package itch_axis_pkg;

  typedef logic [7:0] byte_t;

  // Helpers work on a mask widened to the largest supported lane count (128/8).
  localparam int unsigned MAX_LANES  = 16;
  localparam int unsigned LANE_IDX_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } unpack_state_t;

  // Number of byte lanes in a word of the given bit width.
  function automatic int unsigned lane_count(input int unsigned width);
    return width / 8;
  endfunction

  // Index of the next lane to emit: lowest set bit when lsb_first, else highest.
  function automatic logic [LANE_IDX_W-1:0] pick_lane(input logic [MAX_LANES-1:0] mask,
                                                      input logic                 lsb_first);
    logic [LANE_IDX_W-1:0] idx;
    idx = '0;
    if (lsb_first) begin
      for (int i = int'(MAX_LANES) - 1; i >= 0; i--) begin
        if (mask[i]) idx = LANE_IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(MAX_LANES); i++) begin
        if (mask[i]) idx = LANE_IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one lane remains in the mask.
  function automatic logic popcount_is_one(input logic [MAX_LANES-1:0] mask);
    return (mask != '0) && ((mask & (mask - MAX_LANES'(1))) == '0);
  endfunction

endpackage

// File: rtl/itch_word_fifo.sv
// Synchronous word FIFO with extra-MSB pointers, synchronous clear and a level output.
module itch_word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign do_wr     = wr_en && !full_c && !clr;
  assign do_rd     = rd_en && !empty_c && !clr;
  assign level_c   = wr_ptr - rd_ptr;
  assign full_c    = (level_c == PW'(DEPTH));
  assign empty_c   = (wr_ptr == rd_ptr);
  assign rd_data_c = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear takes priority over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/itch_axis_byte_serializer.sv
// AXI-Stream word to byte serializer: word FIFO, TKEEP-aware unpacker, TLAST marking.
// Define ITCH_SER_STATS_EN to add byte_count / msg_count statistics outputs.
module itch_axis_byte_serializer
  import itch_axis_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LSB_FIRST   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                           s_axis_tlast,
  output logic [7:0]                     out_byte,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  input  logic                           flush,
`ifdef ITCH_SER_STATS_EN
  output logic [31:0]                    byte_count,
  output logic [31:0]                    msg_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [15:0]                    null_words
);

  localparam int unsigned LANES   = lane_count(TDATA_WIDTH);
  localparam int unsigned ENTRY_W = TDATA_WIDTH + LANES + 1;
  localparam logic        LSB_SEL = (LSB_FIRST != 0);

  logic                   in_hs;
  logic                   wr_en;
  logic                   null_hs;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   fire;
  logic [ENTRY_W-1:0]     head;
  logic [TDATA_WIDTH-1:0] head_data;
  logic [LANES-1:0]       head_keep;
  logic                   head_last;

  unpack_state_t          state;
  unpack_state_t          state_n;
  logic [TDATA_WIDTH-1:0] data_reg;
  logic [TDATA_WIDTH-1:0] data_n;
  logic [LANES-1:0]       mask_reg;
  logic [LANES-1:0]       mask_n;
  logic                   last_reg;
  logic                   last_n;
  logic                   valid_n;
  byte_t                  byte_n;
  logic                   out_last_n;
  logic [LANE_IDX_W-1:0]  lane_cur;
  logic [LANE_IDX_W-1:0]  lane_nxt;
  logic [LANES-1:0]       lane_bit;

  // Input acceptance: blocked by reset, a full FIFO, or a flush in this cycle.
  assign s_axis_tready = !rst && !fifo_full && !flush;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign wr_en         = in_hs && (s_axis_tkeep != '0);
  assign null_hs       = in_hs && (s_axis_tkeep == '0);
  assign fire          = out_valid && out_ready;

  assign head_data = head[TDATA_WIDTH-1:0];
  assign head_keep = head[TDATA_WIDTH +: LANES];
  assign head_last = head[ENTRY_W-1];

  itch_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .wr_en     (wr_en),
    .wr_data   ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en     (pop),
    .rd_data_c (head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .level_c   (fifo_level)
  );

  // Saturating count of words dropped for an all-zero keep mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      null_words <= '0;
    end else if (null_hs && (null_words != 16'hFFFF)) begin
      null_words <= null_words + 16'd1;
    end
  end

  // Unpacker state and registered byte outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_reg  <= '0;
      mask_reg  <= '0;
      last_reg  <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      data_reg  <= data_n;
      mask_reg  <= mask_n;
      last_reg  <= last_n;
      out_valid <= valid_n;
      out_byte  <= byte_n;
      out_last  <= out_last_n;
    end
  end

  // Next-state: retire the current lane, reload from the FIFO head without a bubble.
  always_comb begin
    state_n    = state;
    data_n     = data_reg;
    mask_n     = mask_reg;
    last_n     = last_reg;
    pop        = 1'b0;
    lane_bit   = '0;
    byte_n     = '0;
    lane_cur   = pick_lane(MAX_LANES'(mask_reg), LSB_SEL);

    for (int i = 0; i < int'(LANES); i++) begin
      lane_bit[i] = (LANE_IDX_W'(i) == lane_cur);
    end

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_n  = head_data;
          mask_n  = head_keep;
          last_n  = head_last;
          state_n = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (fire) begin
          mask_n = mask_reg & ~lane_bit;
          if (mask_n == '0) begin
            if (!fifo_empty) begin
              pop    = 1'b1;
              data_n = head_data;
              mask_n = head_keep;
              last_n = head_last;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (flush) begin
      state_n = ST_IDLE;
      mask_n  = '0;
      pop     = 1'b0;
    end

    valid_n  = (state_n == ST_EMIT);
    lane_nxt = pick_lane(MAX_LANES'(mask_n), LSB_SEL);
    for (int i = 0; i < int'(LANES); i++) begin
      if (valid_n && (LANE_IDX_W'(i) == lane_nxt)) byte_n = data_n[i*8 +: 8];
    end
    out_last_n = valid_n && last_n && popcount_is_one(MAX_LANES'(mask_n));
  end

`ifdef ITCH_SER_STATS_EN
  // Free-running byte and message counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= '0;
      msg_count  <= '0;
    end else begin
      if (fire) byte_count <= byte_count + 32'd1;
      if (fire && out_last) msg_count <= msg_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_itch_axis_byte_serializer.sv
// Self-checking bench for itch_axis_byte_serializer (32-bit LSB-first and 64-bit MSB-first).
module tb_itch_axis_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        flush;
  logic [2:0]  fifo_level;
  logic [15:0] null_words;

  logic        d64_tvalid;
  logic        d64_tready;
  logic [63:0] d64_tdata;
  logic [7:0]  d64_tkeep;
  logic        d64_tlast;
  logic [7:0]  d64_byte;
  logic        d64_valid;
  logic        d64_ready;
  logic        d64_last;
  logic        d64_flush;
  logic [2:0]  d64_level;
  logic [15:0] d64_null;

`ifdef ITCH_SER_STATS_EN
  logic [31:0] byte_count;
  logic [31:0] msg_count;
  logic [31:0] d64_bc;
  logic [31:0] d64_mc;
`endif

  always #5 clk = ~clk;

  itch_axis_byte_serializer #(.TDATA_WIDTH(32), .FIFO_DEPTH(4), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .flush(flush),
`ifdef ITCH_SER_STATS_EN
    .byte_count(byte_count), .msg_count(msg_count),
`endif
    .fifo_level(fifo_level), .null_words(null_words)
  );

  itch_axis_byte_serializer #(.TDATA_WIDTH(64), .FIFO_DEPTH(4), .LSB_FIRST(0)) dut64 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(d64_tvalid), .s_axis_tready(d64_tready),
    .s_axis_tdata(d64_tdata), .s_axis_tkeep(d64_tkeep), .s_axis_tlast(d64_tlast),
    .out_byte(d64_byte), .out_valid(d64_valid), .out_ready(d64_ready), .out_last(d64_last),
    .flush(d64_flush),
`ifdef ITCH_SER_STATS_EN
    .byte_count(d64_bc), .msg_count(d64_mc),
`endif
    .fifo_level(d64_level), .null_words(d64_null)
  );

  int total = 0;
  int bad   = 0;
  int exp_null = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } ob_t;
  ob_t exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          n;
    logic [7:0]  eb[4];
  } vec_t;
  vec_t tbl[6];

  logic [7:0] got_b[64];
  logic       got_l[64];
  int         got_cyc[64];
  int         got_n;
  bit         done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: kept lanes in emission order, last flag on the final kept byte of a tlast word.
  function automatic void model_push(input logic [63:0] data, input logic [7:0] keep,
                                     input logic last, input int lanes, input bit lsb);
    int order[$];
    for (int k = 0; k < lanes; k++) begin
      int ln;
      ln = lsb ? k : lanes - 1 - k;
      if (keep[ln]) order.push_back(ln);
    end
    if (order.size() == 0) begin
      exp_null++;
      return;
    end
    for (int j = 0; j < order.size(); j++) begin
      ob_t o;
      o.b = data[order[j]*8 +: 8];
      o.l = last && (j == order.size() - 1);
      exp_q.push_back(o);
    end
  endfunction

  task automatic collect(input bit sel, input int n, input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < n; c++) begin
      @(negedge clk);
      if (sel ? (d64_valid && d64_ready) : (out_valid && out_ready)) begin
        got_b[got_n]   = sel ? d64_byte : out_byte;
        got_l[got_n]   = sel ? d64_last : out_last;
        got_cyc[got_n] = c;
        got_n++;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit hs;
    hs = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    check("send_hs", 64'(hs), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] lat_exp[4];
    logic [7:0] hold_b;
    bit         hs;
    int         acc;

    tbl[0] = '{32'hDDCCBBAA, 4'b1010, 1'b1, 2, '{8'hBB, 8'hDD, 8'h00, 8'h00}};
    tbl[1] = '{32'h12345678, 4'b0001, 1'b0, 1, '{8'h78, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{32'h12345678, 4'b1000, 1'b1, 1, '{8'h12, 8'h00, 8'h00, 8'h00}};
    tbl[3] = '{32'hCAFEBABE, 4'b0110, 1'b0, 2, '{8'hBA, 8'hFE, 8'h00, 8'h00}};
    tbl[4] = '{32'h01020304, 4'b1001, 1'b1, 2, '{8'h04, 8'h01, 8'h00, 8'h00}};
    tbl[5] = '{32'hA5B6C7D8, 4'b1111, 1'b0, 4, '{8'hD8, 8'hC7, 8'hB6, 8'hA5}};
    lat_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    d64_tvalid = 1'b0; d64_tdata = '0; d64_tkeep = '0; d64_tlast = 1'b0;
    d64_ready = 1'b1; d64_flush = 1'b0;
    done = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_byte", 64'(out_byte), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_null", 64'(null_words), 64'd0);
`ifdef ITCH_SER_STATS_EN
    check("rst_bc", 64'(byte_count), 64'd0);
    check("rst_mc", 64'(msg_count), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("release_tready", 64'(s_axis_tready), 64'd1);
    check("d64_release_tready", 64'(d64_tready), 64'd1);
    @(posedge clk);
    #1;

    // Latency and back-to-back bytes of one full word
    s_axis_tdata = 32'h44332211; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("lat_hs", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    check("lat_not_yet", 64'(out_valid), 64'd0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_valid%0d", j), 64'(out_valid), 64'd1);
      check($sformatf("lat_byte%0d", j), 64'(out_byte), 64'(lat_exp[j]));
      check($sformatf("lat_last%0d", j), 64'(out_last), 64'(j == 3));
    end
    @(posedge clk);
    #1;
    check("drop_empty", 64'(out_valid), 64'd0);

    // Table-driven single words
    for (int i = 0; i < 6; i++) begin
      fork
        send_word(tbl[i].data, tbl[i].keep, tbl[i].last);
        collect(1'b0, tbl[i].n, 40);
      join
      check($sformatf("tbl%0d_count", i), 64'(got_n), 64'(tbl[i].n));
      for (int j = 0; j < tbl[i].n; j++) begin
        check($sformatf("tbl%0d_byte%0d", i, j), 64'(got_b[j]), 64'(tbl[i].eb[j]));
        check($sformatf("tbl%0d_last%0d", i, j), 64'(got_l[j]),
              64'(tbl[i].last && (j == tbl[i].n - 1)));
      end
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_idle", i), 64'(out_valid), 64'd0);
    end

    // All-zero keep word is dropped and counted
    send_word(32'hFFFFFFFF, 4'h0, 1'b1);
    exp_null++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("null_no_out", 64'(out_valid), 64'd0);
    end
    check("null_count", 64'(null_words), 64'(exp_null));
    check("null_level", 64'(fifo_level), 64'd0);

    // Backpressure: five words fit (one in the unpacker, four in the FIFO)
    exp_q.delete();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      s_axis_tdata  = 32'h10203040 + 32'(acc) * 32'h01010101;
      s_axis_tkeep  = 4'hF;
      s_axis_tlast  = 1'(acc % 2);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        model_push(64'(s_axis_tdata), 8'(s_axis_tkeep), s_axis_tlast, 4, 1'b1);
        acc++;
      end
    end
    s_axis_tvalid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd5);
    check("bp_level", 64'(fifo_level), 64'd4);
    check("bp_tready", 64'(s_axis_tready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_first", 64'(out_byte), 64'h40);
    hold_b = out_byte;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_byte", 64'(out_byte), 64'(hold_b));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    collect(1'b0, 20, 60);
    check("bp_count", 64'(got_n), 64'd20);
    for (int j = 0; j < got_n; j++) begin
      ob_t o;
      o = exp_q.pop_front();
      check($sformatf("bp_byte%0d", j), 64'(got_b[j]), 64'(o.b));
      check($sformatf("bp_last%0d", j), 64'(got_l[j]), 64'(o.l));
    end
    @(posedge clk);
    #1;
    check("bp_idle", 64'(out_valid), 64'd0);

    // Flush mid-word with a competing input word
    s_axis_tdata = 32'h44332211; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tdata = 32'h88776655;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    check("fl_b0", 64'(out_byte), 64'h11);
    check("fl_level1", 64'(fifo_level), 64'd1);
    @(posedge clk);
    #1;
    check("fl_b1", 64'(out_byte), 64'h22);
    @(posedge clk);
    #1;
    check("fl_b2", 64'(out_byte), 64'h33);
    flush = 1'b1;
    s_axis_tdata = 32'hDEADBEEF; s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("fl_tready", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    s_axis_tvalid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_last", 64'(out_last), 64'd0);
    check("fl_level", 64'(fifo_level), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("fl_no_write", 64'(out_valid), 64'd0);
    end
    check("fl_null_kept", 64'(null_words), 64'(exp_null));
    fork
      send_word(32'h99AABBCC, 4'hF, 1'b1);
      collect(1'b0, 4, 30);
    join
    check("fl_after_count", 64'(got_n), 64'd4);
    check("fl_after_b0", 64'(got_b[0]), 64'hCC);
    check("fl_after_b3", 64'(got_b[3]), 64'h99);
    check("fl_after_l3", 64'(got_l[3]), 64'd1);
    @(posedge clk);
    #1;

    // 64-bit MSB-first, two back-to-back words without a gap
    d64_tdata = 64'h0102030405060708; d64_tkeep = 8'hFF; d64_tlast = 1'b0; d64_tvalid = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        d64_tdata = 64'h1112131415161718; d64_tlast = 1'b1;
        @(posedge clk);
        #1;
        d64_tvalid = 1'b0;
      end
      collect(1'b1, 16, 40);
    join
    check("w64_count", 64'(got_n), 64'd16);
    for (int j = 0; j < got_n; j++) begin
      int e;
      e = (j < 8) ? (j + 1) : ('h11 + j - 8);
      check($sformatf("w64_byte%0d", j), 64'(got_b[j]), 64'(e));
      check($sformatf("w64_last%0d", j), 64'(got_l[j]), 64'(j == 15));
    end
    check("w64_no_gap", 64'(got_cyc[15] - got_cyc[0]), 64'd15);
    @(posedge clk);
    #1;
    check("w64_idle", 64'(d64_valid), 64'd0);
    check("w64_level", 64'(d64_level), 64'd0);
    check("w64_null", 64'(d64_null), 64'd0);

    // Randomized traffic against the reference model
    exp_q.delete();
    fork
      begin
        for (int w = 0; w < 250; w++) begin
          bit whs;
          whs = 1'b0;
          s_axis_tdata  = $urandom;
          s_axis_tkeep  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
          s_axis_tlast  = 1'($urandom);
          s_axis_tvalid = 1'b1;
          for (int c = 0; c < 200 && !whs; c++) begin
            @(negedge clk);
            whs = s_axis_tready;
            @(posedge clk);
            #1;
          end
          s_axis_tvalid = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        bit         prev_stall;
        logic [7:0] pb;
        logic       pl;
        prev_stall = 1'b0;
        pb = '0;
        pl = 1'b0;
        for (int c = 0; c < 20000; c++) begin
          @(negedge clk);
          if (prev_stall) begin
            check("rnd_stall_valid", 64'(out_valid), 64'd1);
            check("rnd_stall_byte", 64'(out_byte), 64'(pb));
            check("rnd_stall_last", 64'(out_last), 64'(pl));
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rnd_extra_byte", 64'(exp_q.size()), 64'd1);
            end else begin
              ob_t o;
              o = exp_q.pop_front();
              check("rnd_byte", 64'(out_byte), 64'(o.b));
              check("rnd_last", 64'(out_last), 64'(o.l));
            end
          end
          if (s_axis_tvalid && s_axis_tready)
            model_push(64'(s_axis_tdata), 8'(s_axis_tkeep), s_axis_tlast, 4, 1'b1);
          prev_stall = out_valid && !out_ready;
          pb = out_byte;
          pl = out_last;
          if (done && exp_q.size() == 0 && !out_valid) break;
        end
      end
    join
    check("rnd_drained", 64'(exp_q.size()), 64'd0);
    check("rnd_null", 64'(null_words), 64'(exp_null));
    @(posedge clk);
    #1;

    // Asynchronous reset mid-emit discards all partial state
    s_axis_tdata = 32'hA4A3A2A1; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tdata = 32'hB4B3B2B1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_last", 64'(out_last), 64'd0);
    check("arst_byte", 64'(out_byte), 64'd0);
    check("arst_level", 64'(fifo_level), 64'd0);
    check("arst_tready", 64'(s_axis_tready), 64'd0);
    check("arst_null", 64'(null_words), 64'd0);
`ifdef ITCH_SER_STATS_EN
    check("arst_bc", 64'(byte_count), 64'd0);
    check("arst_mc", 64'(msg_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("arst_release_tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;
    fork
      send_word(32'h0D0C0B0A, 4'hF, 1'b1);
      collect(1'b0, 4, 30);
    join
    check("post_count", 64'(got_n), 64'd4);
    for (int j = 0; j < got_n; j++) begin
      check($sformatf("post_byte%0d", j), 64'(got_b[j]), 64'(8'h0A + 8'(j)));
      check($sformatf("post_last%0d", j), 64'(got_l[j]), 64'(j == 3));
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("post_no_stale", 64'(out_valid), 64'd0);
    end
`ifdef ITCH_SER_STATS_EN
    check("post_bc", 64'(byte_count), 64'd4);
    check("post_mc", 64'(msg_count), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
